// File: rtl/vga_pkg.sv
// Shared VGA timing constants, derived widths and pixel-pipeline helpers.
// Pure declarations: no latency or flow-control behaviour of its own.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int SCALE_SHIFT = 1;
    localparam int MEM_LATENCY = 1;
    localparam int INDEX_W     = 8;
    localparam int COLOR_W     = 4;

    localparam int X_W = $clog2(H_VISIBLE);
    localparam int Y_W = $clog2(V_VISIBLE);

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    // Address register, memory, then palette register.
    function automatic int pipe_latency(input int mem_latency);
        return 2 + mem_latency;
    endfunction

    function automatic int fb_addr_width(input int h, input int v, input int s);
        return $clog2((h >> s) * (v >> s));
    endfunction

    localparam int AW = fb_addr_width(H_VISIBLE, V_VISIBLE, SCALE_SHIFT);
    localparam int L  = pipe_latency(MEM_LATENCY);

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with async active-low clear.
// Latency DEPTH clocks; always shifts, no backpressure.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_framebuffer_reader.sv
// Downscaled framebuffer fetch + palette lookup, syncs re-aligned to the colour.
// Latency 2 + p_MEM_LATENCY clocks; free-running, no backpressure or stall.
module vga_framebuffer_reader
    import vga_pkg::*;
#(
    parameter int p_H_VISIBLE_AREA = H_VISIBLE,
    parameter int p_V_VISIBLE_AREA = V_VISIBLE,
    parameter int p_SCALE_SHIFT    = SCALE_SHIFT,
    parameter int p_MEM_LATENCY    = MEM_LATENCY,
    parameter int p_INDEX_WIDTH    = INDEX_W,
    parameter int p_COLOR_WIDTH    = COLOR_W,
    localparam int XW = $clog2(p_H_VISIBLE_AREA),
    localparam int YW = $clog2(p_V_VISIBLE_AREA),
    localparam int FB_AW = fb_addr_width(p_H_VISIBLE_AREA, p_V_VISIBLE_AREA, p_SCALE_SHIFT)
) (
    input  logic                       i_VGA_CLOCK,
    input  logic                       i_RESET_N,
    input  logic                       i_VGA_SYNC_H,
    input  logic                       i_VGA_SYNC_V,
    input  logic                       i_DRAW_ENABLE,
    input  logic [XW-1:0]              i_SCANLINE_X,
    input  logic [YW-1:0]              i_SCANLINE_Y,
    output logic [FB_AW-1:0]           o_FB_ADDR,
    output logic                       o_FB_READ,
    input  logic [p_INDEX_WIDTH-1:0]   i_FB_DATA,
    input  logic                       i_PAL_WE,
    input  logic [p_INDEX_WIDTH-1:0]   i_PAL_ADDR,
    input  logic [3*p_COLOR_WIDTH-1:0] i_PAL_DATA,
    output logic                       o_VGA_SYNC_H,
    output logic                       o_VGA_SYNC_V,
    output logic [p_COLOR_WIDTH-1:0]   o_VGA_R,
    output logic [p_COLOR_WIDTH-1:0]   o_VGA_G,
    output logic [p_COLOR_WIDTH-1:0]   o_VGA_B
);

    localparam int CW     = p_COLOR_WIDTH;
    localparam int PW     = 3 * CW;
    localparam int FB_W   = p_H_VISIBLE_AREA >> p_SCALE_SHIFT;
    localparam int FULL_W = XW + YW + 1;
    localparam int LAT    = pipe_latency(p_MEM_LATENCY);

    logic [FULL_W-1:0] addr_full;
    logic [FB_AW-1:0]  addr_d, addr_q;
    logic              read_q;
    logic [PW-1:0]     rgb_d, rgb_q;
    logic [PW-1:0]     palette_q [2**p_INDEX_WIDTH];
    logic [2:0]        dly_out;
    logic              en_dly;

    // FB_W is constant, so the multiply folds into a shift-add.
    assign addr_full = FULL_W'(i_SCANLINE_Y >> p_SCALE_SHIFT) * FULL_W'(FB_W)
                     + FULL_W'(i_SCANLINE_X >> p_SCALE_SHIFT);
    assign addr_d    = FB_AW'(addr_full);

    // Read-before-write: a same-cycle write to this index shows next time.
    assign rgb_d = palette_q[i_FB_DATA];

    always_ff @(posedge i_VGA_CLOCK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            addr_q <= '0;
            read_q <= 1'b0;
            rgb_q  <= '0;
        end else begin
            addr_q <= addr_d;
            read_q <= i_DRAW_ENABLE;
            rgb_q  <= rgb_d;
        end
    end

    always_ff @(posedge i_VGA_CLOCK) begin
        if (i_PAL_WE) begin
            palette_q[i_PAL_ADDR] <= i_PAL_DATA;
        end
    end

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (LAT)
    ) u_sync_dly (
        .clk_i   (i_VGA_CLOCK),
        .rst_n_i (i_RESET_N),
        .d_i     ({i_VGA_SYNC_H, i_VGA_SYNC_V, i_DRAW_ENABLE}),
        .q_o     (dly_out)
    );

    assign en_dly       = dly_out[0];
    assign o_VGA_SYNC_H = dly_out[2];
    assign o_VGA_SYNC_V = dly_out[1];
    assign o_VGA_R      = en_dly ? rgb_q[PW-1 -: CW]   : '0;
    assign o_VGA_G      = en_dly ? rgb_q[2*CW-1 -: CW] : '0;
    assign o_VGA_B      = en_dly ? rgb_q[CW-1:0]       : '0;
    assign o_FB_ADDR    = addr_q;
    assign o_FB_READ    = read_q;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Bench: default reader plus a latency-3 / unscaled variant, both checked against
// a cycle-indexed behavioural model of pixel, sync and palette semantics.
module tb_vga_framebuffer_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hs = 1'b0, vs = 1'b0, en = 1'b0;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic        pal_we = 1'b0;
    logic [7:0]  pal_addr = '0;
    logic [11:0] pal_data = '0;

    logic [16:0] addr1;
    logic        rd1, hs1, vs1;
    logic [7:0]  data1;
    logic [3:0]  r1, g1, b1;
    logic [18:0] addr2;
    logic        rd2, hs2, vs2;
    logic [7:0]  data2;
    logic [3:0]  r2, g2, b2;

    always #5 clk = ~clk;

    vga_framebuffer_reader dut1 (
        .i_VGA_CLOCK(clk), .i_RESET_N(rst_n), .i_VGA_SYNC_H(hs), .i_VGA_SYNC_V(vs),
        .i_DRAW_ENABLE(en), .i_SCANLINE_X(x), .i_SCANLINE_Y(y),
        .o_FB_ADDR(addr1), .o_FB_READ(rd1), .i_FB_DATA(data1),
        .i_PAL_WE(pal_we), .i_PAL_ADDR(pal_addr), .i_PAL_DATA(pal_data),
        .o_VGA_SYNC_H(hs1), .o_VGA_SYNC_V(vs1), .o_VGA_R(r1), .o_VGA_G(g1), .o_VGA_B(b1)
    );

    vga_framebuffer_reader #(.p_MEM_LATENCY(3), .p_SCALE_SHIFT(0)) dut2 (
        .i_VGA_CLOCK(clk), .i_RESET_N(rst_n), .i_VGA_SYNC_H(hs), .i_VGA_SYNC_V(vs),
        .i_DRAW_ENABLE(en), .i_SCANLINE_X(x), .i_SCANLINE_Y(y),
        .o_FB_ADDR(addr2), .o_FB_READ(rd2), .i_FB_DATA(data2),
        .i_PAL_WE(pal_we), .i_PAL_ADDR(pal_addr), .i_PAL_DATA(pal_data),
        .o_VGA_SYNC_H(hs2), .o_VGA_SYNC_V(vs2), .o_VGA_R(r2), .o_VGA_G(g2), .o_VGA_B(b2)
    );

    // Framebuffer memories: 320x240 array (latency 1) and a hashed 640x480 (latency 3).
    logic [7:0] fb_mem [0:76799];
    logic [7:0] m2 [0:2];

    function automatic logic [7:0] fbv2(input logic [18:0] a);
        return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]};
    endfunction

    always @(posedge clk) begin
        data1 <= (addr1 < 17'd76800) ? fb_mem[addr1] : 8'h00;
        m2[0] <= fbv2(addr2);
        m2[1] <= m2[0];
        m2[2] <= m2[1];
    end
    assign data2 = m2[2];

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       en;
        logic [9:0] x;
        logic [8:0] y;
    } ent_t;

    ent_t        hist[$];
    logic [11:0] pal_m [256];
    logic [11:0] pal_init [256];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [16:0] a1(input ent_t e);
        return 17'((int'(e.y) >> 1) * 320 + (int'(e.x) >> 1));
    endfunction

    function automatic logic [18:0] a2(input ent_t e);
        return 19'(int'(e.y) * 640 + int'(e.x));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, predict from input history, compare after posedge.
    task automatic step(input logic s_hs, input logic s_vs, input logic s_en,
                        input logic [9:0] s_x, input logic [8:0] s_y,
                        input logic s_we, input logic [7:0] s_pa, input logic [11:0] s_pd);
        ent_t        e, e1, e2;
        logic [13:0] exp1, exp2;
        int          c;
        @(negedge clk);
        hs = s_hs; vs = s_vs; en = s_en; x = s_x; y = s_y;
        pal_we = s_we; pal_addr = s_pa; pal_data = s_pd;
        e.hs = s_hs; e.vs = s_vs; e.en = s_en; e.x = s_x; e.y = s_y;
        if (!rst_n) e = '0;
        hist.push_back(e);
        c  = hist.size() - 1;
        e1 = hist[c-2];
        e2 = hist[c-4];
        exp1 = {e1.hs, e1.vs, e1.en ? pal_m[fb_mem[a1(e1)]] : 12'h000};
        exp2 = {e2.hs, e2.vs, e2.en ? pal_m[fbv2(a2(e2))] : 12'h000};
        if (s_we) pal_m[s_pa] = s_pd;
        @(posedge clk);
        #1;
        check("pix1", 32'({hs1, vs1, r1, g1, b1}), 32'(exp1));
        check("pix2", 32'({hs2, vs2, r2, g2, b2}), 32'(exp2));
        check("read1", 32'(rd1), 32'(e.en));
        check("read2", 32'(rd2), 32'(e.en));
        if (e.en) begin
            check("addr1", 32'(addr1), 32'(a1(e)));
            check("addr2", 32'(addr2), 32'(a2(e)));
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 1'b0, 8'd0, 12'h000);
    endtask

    task automatic rand_step(input logic allow_we);
        logic       r_en;
        logic [9:0] r_x;
        logic [8:0] r_y;
        r_en = 1'($urandom);
        r_x  = r_en ? 10'($urandom_range(0, 639)) : 10'($urandom);
        r_y  = r_en ? 9'($urandom_range(0, 479))  : 9'($urandom);
        step(1'($urandom), 1'($urandom), r_en, r_x, r_y,
             allow_we && ($urandom_range(0, 7) == 0), 8'($urandom), 12'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 76800; i++) fb_mem[i] = 8'($urandom);
        fb_mem[3205]  = 8'h2A;   // (x=10, y=20)
        fb_mem[16050] = 8'h07;   // (x=100, y=100)
        for (int i = 0; i < 256; i++) pal_init[i] = 12'($urandom);
        pal_init[8'h2A] = 12'hF81;
        pal_init[8'h07] = 12'h00F;
        for (int i = 0; i < 8; i++) hist.push_back('0);

        // Reset held while inputs toggle; palette loads meanwhile.
        for (int i = 0; i < 256; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 10'($urandom), 9'($urandom),
                 1'b1, 8'(i), pal_init[i]);
        end
        check("rst_outputs", 32'({hs1, vs1, r1, g1, b1, rd1}), 32'd0);
        rst_n = 1'b1;

        // Address generation and post-reset sync latency.
        step(1'b1, 1'b0, 1'b1, 10'd0, 9'd0, 1'b0, 8'd0, 12'h000);
        check("addr_0_0", 32'(addr1), 32'd0);
        check("rd_after_en", 32'(rd1), 32'd1);
        step(1'b0, 1'b0, 1'b1, 10'd639, 9'd479, 1'b0, 8'd0, 12'h000);
        check("hs_not_early", 32'(hs1), 32'd0);
        check("addr_max", 32'(addr1), 32'd76799);
        check("addr2_max", 32'(addr2), 32'd307199);
        step(1'b0, 1'b0, 1'b1, 10'd5, 9'd3, 1'b0, 8'd0, 12'h000);
        check("hs_latency3", 32'(hs1), 32'd1);
        check("addr_5_3", 32'(addr1), 32'd322);
        step(1'b0, 1'b0, 1'b1, 10'd4, 9'd2, 1'b0, 8'd0, 12'h000);
        check("addr_4_2", 32'(addr1), 32'd322);
        repeat (5) idle();

        // Colour path through palette entry 0x2A, then blanking.
        step(1'b0, 1'b0, 1'b1, 10'd10, 9'd20, 1'b0, 8'd0, 12'h000);
        idle();
        idle();
        check("rgb_f81", 32'({r1, g1, b1}), 32'h0F81);
        idle();
        check("rgb_blank", 32'({r1, g1, b1}), 32'h0000);

        // Palette write colliding with the lookup of the same index.
        step(1'b0, 1'b0, 1'b1, 10'd100, 9'd100, 1'b0, 8'd0, 12'h000);
        idle();
        step(1'b0, 1'b0, 1'b0, 10'd0, 9'd0, 1'b1, 8'h07, 12'h0F0);
        check("coll_old", 32'({r1, g1, b1}), 32'h000F);
        step(1'b0, 1'b0, 1'b1, 10'd100, 9'd100, 1'b0, 8'd0, 12'h000);
        idle();
        idle();
        check("coll_new", 32'({r1, g1, b1}), 32'h00F0);
        repeat (5) idle();

        // Bottom of a frame from a driver model, spanning vertical sync.
        for (int v = 478; v < 493; v++) begin
            for (int h = 0; h < 800; h++) begin
                logic f_en;
                f_en = (h < 640) && (v < 480);
                step(!(h >= 656 && h < 752), !(v >= 490 && v < 492), f_en,
                     f_en ? 10'(h) : 10'($urandom), f_en ? 9'(v) : 9'($urandom),
                     1'b0, 8'd0, 12'h000);
            end
        end

        repeat (2000) rand_step(1'b1);

        // Asynchronous reset mid-stream flushes the pipeline.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst1", 32'({addr1, rd1, hs1, vs1, r1, g1, b1}), 32'd0);
        check("async_rst2", 32'({addr2, rd2, hs2, vs2, r2, g2, b2}), 32'd0);
        for (int i = 0; i < 6; i++) hist[hist.size() - 1 - i] = '0;
        repeat (3) rand_step(1'b0);
        rst_n = 1'b1;
        repeat (300) rand_step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
